// File: rtl/regfile_wport_if.sv
// Write-port bundle between the two writeback requesters, the arbiter and the
// register file. The arbiter uses the slave view; the environment uses master.
interface regfile_wport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  logic              req_0;
  logic [ADDR_W-1:0] addr_0;
  logic [DATA_W-1:0] data_0;
  logic              req_1;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] data_1;
  logic              grant_0;
  logic              grant_1;
  logic              sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output req_0, addr_0, data_0, req_1, addr_1, data_1, wr_ready,
    input  grant_0, grant_1, sel, wr_en, wr_addr, wr_data, conflict_cnt
  );

  modport slave (
    input  req_0, addr_0, data_0, req_1, addr_1, data_1, wr_ready,
    output grant_0, grant_1, sel, wr_en, wr_addr, wr_data, conflict_cnt
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU
// writeback (requester 0) and load writeback (requester 1). The winning write
// lands in a one-entry output stage that holds under regfile back-pressure.
// Writes to register $0 are consumed without reaching the regfile.
module regfile_wport_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input logic             clk,
  input logic             rst_n,
  regfile_wport_if.slave  bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic              last_q;
  logic              grant_0, grant_1;
  logic              can_accept;
  logic              win_sel;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic              sel_p0;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign can_accept = (state_q == IDLE) || bus.wr_ready;
  assign win_sel    = grant_1;
  assign win_addr   = grant_1 ? bus.addr_1 : bus.addr_0;
  assign win_data   = grant_1 ? bus.data_1 : bus.data_0;

  // Grant selection (round-robin on contention) and next FSM state.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    state_d = state_q;
    if (rst_n && can_accept) begin
      if (bus.req_0 && bus.req_1) begin
        if (last_q) grant_0 = 1'b1;
        else        grant_1 = 1'b1;
      end else if (bus.req_0) begin
        grant_0 = 1'b1;
      end else if (bus.req_1) begin
        grant_1 = 1'b1;
      end
    end
    if (grant_0 || grant_1) begin
      state_d = (win_addr != '0) ? HOLD : IDLE;
    end else if ((state_q == HOLD) && bus.wr_ready) begin
      state_d = IDLE;
    end
  end

  // FSM state register; reset drops any pending write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Output stage capture and last-grant pointer, updated only on granting edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0 <= '0;
      data_p0 <= '0;
      sel_p0  <= 1'b0;
      last_q  <= 1'b1;
    end else if (grant_0 || grant_1) begin
      addr_p0 <= win_addr;
      data_p0 <= win_data;
      sel_p0  <= win_sel;
      last_q  <= win_sel;
    end
  end

  // Contention counter: every edge with both requests high, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt_q <= '0;
    else if (bus.req_0 && bus.req_1)  cnt_q <= sat_inc(cnt_q);
  end

  assign bus.grant_0      = grant_0;
  assign bus.grant_1      = grant_1;
  assign bus.wr_en        = (state_q == HOLD);
  assign bus.wr_addr      = addr_p0;
  assign bus.wr_data      = data_p0;
  assign bus.sel          = sel_p0;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed vector table, hand-written
// saturation and async-reset sequences, then randomized traffic against a
// transaction-level model of the write port.
module tb_regfile_wport_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  regfile_wport_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  regfile_wport_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          r0;
    logic [4:0]  a0;
    logic [31:0] d0;
    bit          r1;
    logic [4:0]  a1;
    logic [31:0] d1;
    bit          rdy;
    bit          eg0;
    bit          eg1;
    bit          ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    bit          esel;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit r0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit r1, input logic [4:0] a1, input logic [31:0] d1,
                       input bit rdy);
    bus.req_0 = r0; bus.addr_0 = a0; bus.data_0 = d0;
    bus.req_1 = r1; bus.addr_1 = a1; bus.data_1 = d1;
    bus.wr_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Model state for the random phase
  bit          m_pend;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_sel;
  bit          m_last;
  int          m_cnt;
  bit          q_req[2];
  logic [4:0]  q_addr[2];
  logic [31:0] q_data[2];
  int          writes_seen;

  function automatic logic [4:0] rand_addr();
    logic [4:0] a;
    a = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 7) == 0) a = 5'd0;
    return a;
  endfunction

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);

    // rst r0 a0 d0 r1 a1 d1 rdy | g0 g1 we addr data sel cnt
    // Single request after reset
    vecs.push_back('{1,1, 9,32'hDEAD_BEEF,0,0,0,1, 1,0,0, 0,32'h0,0,0});
    vecs.push_back('{0,0, 0,32'h0,0,0,0,1,        0,0,1, 9,32'hDEAD_BEEF,0,0});
    vecs.push_back('{0,0, 0,32'h0,0,0,0,1,        0,0,0, 9,32'hDEAD_BEEF,0,0});
    // Contention round-robin from reset
    vecs.push_back('{1,1, 3,32'h30,1,7,32'h70,1,  1,0,0, 0,32'h0,0,0});
    vecs.push_back('{0,1, 3,32'h30,1,7,32'h70,1,  0,1,1, 3,32'h30,0,1});
    vecs.push_back('{0,1, 3,32'h30,1,7,32'h70,1,  1,0,1, 7,32'h70,1,2});
    vecs.push_back('{0,1, 3,32'h30,1,7,32'h70,1,  0,1,1, 3,32'h30,0,3});
    vecs.push_back('{0,0, 0,32'h0,0,0,0,1,        0,0,1, 7,32'h70,1,4});
    // Back-pressure
    vecs.push_back('{0,0, 0,32'h0,1,12,32'h1234,1,   0,1,0, 7,32'h70,1,4});
    vecs.push_back('{0,1,20,32'hA5A5,0,0,0,0,        0,0,1,12,32'h1234,1,4});
    vecs.push_back('{0,1,20,32'hA5A5,0,0,0,0,        0,0,1,12,32'h1234,1,4});
    vecs.push_back('{0,1,20,32'hA5A5,0,0,0,0,        0,0,1,12,32'h1234,1,4});
    vecs.push_back('{0,1,20,32'hA5A5,0,0,0,1,        1,0,1,12,32'h1234,1,4});
    vecs.push_back('{0,0, 0,32'h0,0,0,0,1,           0,0,1,20,32'hA5A5,0,4});
    // Register $0 suppression, pointer still moves
    vecs.push_back('{1,1, 0,32'hFFFF_FFFF,0,0,0,1,   1,0,0, 0,32'h0,0,0});
    vecs.push_back('{0,1, 4,32'h44,1,6,32'h66,1,     0,1,0, 0,32'hFFFF_FFFF,0,0});
    vecs.push_back('{0,0, 0,32'h0,0,0,0,1,           0,0,1, 6,32'h66,1,1});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].r0, vecs[i].a0, vecs[i].d0, vecs[i].r1, vecs[i].a1, vecs[i].d1, vecs[i].rdy);
      #4;
      chk($sformatf("vec%0d grant_0", i), 64'(bus.grant_0), 64'(vecs[i].eg0));
      chk($sformatf("vec%0d grant_1", i), 64'(bus.grant_1), 64'(vecs[i].eg1));
      chk($sformatf("vec%0d wr_en", i), 64'(bus.wr_en), 64'(vecs[i].ewe));
      chk($sformatf("vec%0d wr_addr", i), 64'(bus.wr_addr), 64'(vecs[i].ea));
      chk($sformatf("vec%0d wr_data", i), 64'(bus.wr_data), 64'(vecs[i].ed));
      chk($sformatf("vec%0d sel", i), 64'(bus.sel), 64'(vecs[i].esel));
      chk($sformatf("vec%0d conflict_cnt", i), 64'(bus.conflict_cnt), 64'(vecs[i].ecnt));
      next_cycle();
    end

    // Counter saturation: both requesting for 300 cycles
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1);
      #4;
      if (i == 254) chk("sat cnt at 254", 64'(bus.conflict_cnt), 64'd254);
      if (i == 299) chk("sat cnt at 299", 64'(bus.conflict_cnt), 64'd255);
      next_cycle();
    end
    chk("sat cnt holds", 64'(bus.conflict_cnt), 64'd255);

    // Async reset while a write is pending
    do_reset();
    drive(1, 5'd5, 32'h55, 1, 5'd9, 32'h99, 0);
    #4;
    chk("hold setup grant_0", 64'(bus.grant_0), 64'd1);
    next_cycle();
    drive(0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0);
    #1;
    chk("hold setup wr_en", 64'(bus.wr_en), 64'd1);
    chk("hold setup wr_addr", 64'(bus.wr_addr), 64'd5);
    chk("hold setup cnt", 64'(bus.conflict_cnt), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst wr_en", 64'(bus.wr_en), 64'd0);
    chk("async rst wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("async rst wr_data", 64'(bus.wr_data), 64'd0);
    chk("async rst cnt", 64'(bus.conflict_cnt), 64'd0);
    chk("async rst grant_1", 64'(bus.grant_1), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(1, 5'd3, 32'h33, 1, 5'd9, 32'h99, 1);
    #4;
    chk("post rst grant_0", 64'(bus.grant_0), 64'd1);
    chk("post rst grant_1", 64'(bus.grant_1), 64'd0);
    next_cycle();

    // Randomized traffic against the write-port model
    do_reset();
    m_pend = 0; m_addr = 0; m_data = 0; m_sel = 0; m_last = 1; m_cnt = 0;
    writes_seen = 0;
    for (int r = 0; r < 2; r++) begin
      q_req[r] = 0; q_addr[r] = 0; q_data[r] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit rdy, can, eg[2], both, any;
      int w;
      for (int r = 0; r < 2; r++) begin
        if (!q_req[r] && ($urandom_range(0, 2) != 0)) begin
          q_req[r] = 1; q_addr[r] = rand_addr(); q_data[r] = $urandom;
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      drive(q_req[0], q_addr[0], q_data[0], q_req[1], q_addr[1], q_data[1], rdy);
      can  = !m_pend || rdy;
      both = q_req[0] && q_req[1];
      eg[0] = 0; eg[1] = 0;
      if (can) begin
        if (both) eg[m_last ? 0 : 1] = 1;
        else if (q_req[0]) eg[0] = 1;
        else if (q_req[1]) eg[1] = 1;
      end
      #4;
      chk("rand grant_0", 64'(bus.grant_0), 64'(eg[0]));
      chk("rand grant_1", 64'(bus.grant_1), 64'(eg[1]));
      chk("rand wr_en", 64'(bus.wr_en), 64'(m_pend));
      chk("rand wr_addr", 64'(bus.wr_addr), 64'(m_addr));
      chk("rand wr_data", 64'(bus.wr_data), 64'(m_data));
      chk("rand sel", 64'(bus.sel), 64'(m_sel));
      chk("rand conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
      if (m_pend && rdy) writes_seen++;
      next_cycle();
      if (both && m_cnt < 255) m_cnt++;
      any = eg[0] || eg[1];
      if (any) begin
        w = eg[1] ? 1 : 0;
        m_addr = q_addr[w]; m_data = q_data[w]; m_sel = w[0]; m_last = w[0];
        m_pend = (q_addr[w] != 0);
        if ($urandom_range(0, 1) == 0) begin
          q_req[w] = 0;
        end else begin
          q_addr[w] = rand_addr(); q_data[w] = $urandom;
        end
      end else if (m_pend && rdy) begin
        m_pend = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: requester 0 is ALU writeback, requester 1 is memory-load writeback.
- Drives the select of the 5-bit destination-address mux and the matching data mux.
- Registers the winning write into a one-entry output stage held under regfile back-pressure.
- Uses round-robin fairness, suppresses writes to register $0, and counts contention cycles.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address (matches the 5-bit destination mux).
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_0  input  1  requester 0 write request.
- addr_0  input  ADDR_W  requester 0 destination register.
- data_0  input  DATA_W  requester 0 write data.
- req_1  input  1  requester 1 write request.
- addr_1  input  ADDR_W  requester 1 destination register.
- data_1  input  DATA_W  requester 1 write data.
- grant_0  output  1  combinational accept for requester 0.
- grant_1  output  1  combinational accept for requester 1.
- sel  output  1  mux select (0 = requester 0, 1 = requester 1), registered with the write.
- wr_en  output  1  regfile write enable.
- wr_addr  output  ADDR_W  registered write address.
- wr_data  output  DATA_W  registered write data.
- wr_ready  input  1  regfile accepts the write this cycle.
- conflict_cnt  output  CNT_W  saturating count of contention cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_en = 0, wr_addr = 0, wr_data = 0, sel = 0, conflict_cnt = 0.
  - FSM goes to IDLE; last-grant pointer = 1, so requester 0 wins first.
  - grant_0 and grant_1 are 0 while rst_n is low.
- FSM states: IDLE (output stage empty) and HOLD (output stage holds a write that has not yet been accepted).
- can_accept = (state == IDLE) or (state == HOLD and wr_ready).
- Grant rules (combinational, same cycle as request):
  - If can_accept and exactly one req is high, grant that requester.
  - If can_accept and both reqs are high, grant the requester not named by the last-grant pointer.
  - At most one grant is high per cycle. No grant when can_accept = 0.
- Requester handshake:
  - A requester holds req, addr and data stable until the cycle its grant is high.
  - The transfer completes at the rising edge where grant is high.
  - The requester may keep req high for back-to-back writes.
- On a granting edge:
  - Capture the winner's addr and data into wr_addr/wr_data, set sel to the winner index, update last-grant to the winner.
  - If the captured addr != 0: wr_en = 1 next cycle, state -> HOLD.
  - If the captured addr == 0: write is consumed silently, wr_en stays/goes 0, state -> IDLE, pointer still updates.
- HOLD with wr_ready = 1 and no new grant: wr_en -> 0, state -> IDLE. wr_addr, wr_data and sel retain their values.
- HOLD with wr_ready = 1 and a new grant: the new write replaces the old one at the same edge (back-to-back, one write per cycle throughput).
- HOLD with wr_ready = 0: outputs frozen, no grants, requests wait.
- Latency: grant at cycle n -> wr_en/wr_addr/wr_data valid from cycle n+1.
- conflict_cnt:
  - Increments on every edge where req_0 and req_1 are both high, whether or not a grant occurs.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset mid-HOLD: the pending write is dropped and never reaches the regfile (wr_en 0 immediately, asynchronously).
- Signals with no requirement:
  - wr_addr/wr_data when wr_en = 0 are don't-care for the regfile but follow the rules above.
  - sel changes only on granting edges.

Test Plan:
- Reset, single request: req_0=1, addr_0=5'd9, data_0=32'hDEAD_BEEF, wr_ready=1 -> grant_0=1 that cycle. Next cycle wr_en=1, wr_addr=9, wr_data=DEADBEEF, sel=0. Following cycle wr_en=0 once req_0 drops.
- Contention round-robin: both reqs held high for 4 cycles, wr_ready=1, addrs 3/7 -> grants alternate 0,1,0,1. sel sequence 0,1,0,1. conflict_cnt=4.
- Back-pressure: grant req_1 (addr 12, data 32'h1234), hold wr_ready=0 for 3 cycles while req_0 is high -> no grant_0; wr_en/wr_addr=12 frozen. wr_ready=1 -> grant_0 that cycle, new write visible next cycle.
- Register $0: req_0 with addr_0=0, data_0=32'hFFFF_FFFF -> grant_0=1, wr_en stays 0. Then both request -> requester 1 wins (pointer updated).
- Counter saturation: CNT_W=8, both reqs high for 300 cycles -> conflict_cnt=255 and holds.
- Async reset in HOLD: wr_ready=0 with wr_en=1 at addr 5, pulse rst_n low mid-cycle -> wr_en=0, wr_addr=0, conflict_cnt=0 immediately. After release, both requesting -> grant_0 first.
